// File: rtl/fcp6_slave.sv
// FCP6 responder: decodes dibit header frames and services
// write/read transfers against a local 8x8 register file.
module fcp6_slave #(
  parameter logic [2:0] SLAVE_ID = 3'b111,
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ctrl,
  input  logic [1:0] data_in,
  output logic [1:0] data_out,
  output logic       data_oe,
  output logic       ack,
  output logic       busy,
  output logic       err,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  typedef enum logic [2:0] {
    IDLE, HDR, WDATA, RDATA, DONE, SKIP
  } state_t;

  localparam logic [1:0] CT_START = 2'b01;
  localparam logic [1:0] CT_XFER  = 2'b10;
  localparam logic [1:0] CT_STOP  = 2'b11;

  state_t     state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic [7:0] shift, shift_nx;
  logic [2:0] addr, addr_nx;
  logic [1:0] dout_nx;
  logic       ack_nx, err_nx, we;
  logic [7:0] regs [8];

  logic       xfer, last, restart, abort;
  logic       hdr_hit;
  logic [7:0] sh_in, rd_byte;

  assign xfer    = (ctrl == CT_XFER);
  assign last    = (cnt == 2'd3);
  assign sh_in   = {shift[5:0], data_in};
  assign rd_byte = regs[sh_in[5:3]];
  assign hdr_hit = (sh_in[2:0] == SLAVE_ID);

  assign restart = (state != IDLE) && (ctrl == CT_START);
  assign abort   = (ctrl == CT_STOP) &&
                   (state inside {HDR, WDATA, RDATA});

  assign busy     = (state != IDLE);
  assign data_oe  = (state == RDATA);
  assign dbg_data = regs[dbg_addr];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shift_nx = shift;
    addr_nx  = addr;
    dout_nx  = data_out;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    we       = 1'b0;
    unique case (1'b1)
      restart: begin
        err_nx   = 1'b1;
        state_nx = HDR;
        cnt_nx   = 2'd0;
        dout_nx  = 2'b00;
      end
      abort: begin
        err_nx   = 1'b1;
        state_nx = IDLE;
        dout_nx  = 2'b00;
      end
      default: begin
        unique case (state)
          IDLE: begin
            if (ctrl == CT_START) begin
              state_nx = HDR;
              cnt_nx   = 2'd0;
            end
          end
          HDR: begin
            if (xfer) begin
              shift_nx = sh_in;
              cnt_nx   = cnt + 2'd1;
              if (last) begin
                addr_nx = sh_in[5:3];
                if (hdr_hit && sh_in[7:6] == 2'b01) begin
                  state_nx = WDATA;
                end else if (hdr_hit &&
                             sh_in[7:6] == 2'b10) begin
                  // snapshot so the byte is stable
                  state_nx = RDATA;
                  shift_nx = rd_byte;
                  dout_nx  = rd_byte[7:6];
                end else begin
                  state_nx = SKIP;
                end
              end
            end
          end
          WDATA: begin
            if (xfer) begin
              shift_nx = sh_in;
              cnt_nx   = cnt + 2'd1;
              if (last) begin
                we       = 1'b1;
                ack_nx   = 1'b1;
                state_nx = DONE;
              end
            end
          end
          RDATA: begin
            if (xfer) begin
              cnt_nx   = cnt + 2'd1;
              shift_nx = {shift[5:0], 2'b00};
              dout_nx  = shift[5:4];
              if (last) begin
                dout_nx  = 2'b00;
                ack_nx   = 1'b1;
                state_nx = DONE;
              end
            end
          end
          DONE: begin
            if (ctrl == CT_STOP) begin
              state_nx = IDLE;
            end else if (xfer) begin
              err_nx   = 1'b1;
              state_nx = SKIP;
            end
          end
          SKIP: begin
            if (ctrl == CT_STOP) state_nx = IDLE;
          end
          default: state_nx = IDLE;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      shift    <= 8'h00;
      addr     <= 3'd0;
      data_out <= 2'b00;
      ack      <= 1'b0;
      err      <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= REG_INIT;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      shift    <= shift_nx;
      addr     <= addr_nx;
      data_out <= dout_nx;
      ack      <= ack_nx;
      err      <= err_nx;
      if (we) regs[addr] <= sh_in;
    end
  end

endmodule

// File: tb/tb_fcp6_slave.sv
// Bench for fcp6_slave: frame-level model compared every cycle,
// plus directed frames with literal expectations.
module tb_fcp6_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [1:0] data_in = 2'b00;
  logic [2:0] dbg_addr = 3'd0;
  logic [1:0] data_out;
  logic       data_oe, ack, busy, err;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_bad = 0;
  bit en = 1'b0;

  fcp6_slave dut (
    .clk(clk), .rst(rst), .ctrl(ctrl), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .ack(ack),
    .busy(busy), .err(err), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Frame model: counts dibits since start and judges the frame
  // from its header once four dibits are in.
  typedef struct {
    bit         in_f;
    int         n;
    logic [7:0] hdr;
    logic [7:0] snap;
    logic [7:0] wbuf;
    bit         ack;
    bit         err;
    bit         we;
  } mdl_t;

  function automatic bit hit(mdl_t s);
    return s.n >= 4 && s.hdr[2:0] == 3'b111 &&
           (s.hdr[7:6] == 2'b01 || s.hdr[7:6] == 2'b10);
  endfunction

  function automatic mdl_t step(mdl_t s, logic [1:0] c,
                                logic [1:0] d,
                                logic [7:0][7:0] mm);
    mdl_t r = s;
    r.ack = 0;
    r.err = 0;
    r.we  = 0;
    case (c)
      2'b01: begin
        if (r.in_f) r.err = 1;
        r.in_f = 1;
        r.n    = 0;
      end
      2'b11: begin
        if (r.in_f) begin
          if (r.n < 4 || (hit(r) && r.n < 8)) r.err = 1;
          r.in_f = 0;
        end
      end
      2'b10: begin
        if (r.in_f) begin
          r.n = r.n + 1;
          if (r.n <= 4) r.hdr = {r.hdr[5:0], d};
          else if (r.n <= 8) r.wbuf = {r.wbuf[5:0], d};
          if (r.n == 4 && hit(r) && r.hdr[7:6] == 2'b10)
            r.snap = mm[r.hdr[5:3]];
          if (r.n == 8 && hit(r)) begin
            r.ack = 1;
            if (r.hdr[7:6] == 2'b01) r.we = 1;
          end
          if (r.n == 9 && hit(r)) r.err = 1;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  mdl_t            ms, nx;
  logic [7:0][7:0] mem;

  always_comb nx = step(ms, ctrl, data_in, mem);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ms  <= '{default: 0};
      mem <= '0;
    end else begin
      ms <= nx;
      if (nx.we) mem[nx.hdr[5:3]] <= nx.wbuf;
    end
  end

  logic       e_oe;
  logic [1:0] e_dout;
  always_comb begin
    e_oe   = ms.in_f && hit(ms) && ms.hdr[7:6] == 2'b10 &&
             ms.n >= 4 && ms.n < 8;
    e_dout = 2'b00;
    if (e_oe) e_dout = 2'(ms.snap >> (2 * (7 - ms.n)));
  end

  always @(negedge clk) begin
    if (en) begin
      chk("m_busy", {7'd0, busy}, {7'd0, ms.in_f});
      chk("m_ack", {7'd0, ack}, {7'd0, ms.ack});
      chk("m_err", {7'd0, err}, {7'd0, ms.err});
      chk("m_oe", {7'd0, data_oe}, {7'd0, e_oe});
      chk("m_dout", {6'd0, data_out}, {6'd0, e_dout});
      chk("m_dbg", dbg_data, mem[dbg_addr]);
    end
  end

  task automatic cyc(input logic [1:0] c, input logic [1:0] d);
    ctrl    = c;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    for (int i = 0; i < 4; i++) cyc(2'b10, b[7-2*i -: 2]);
  endtask

  logic [7:0] rec;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_oe", {7'd0, data_oe}, 8'd0);
    chk("rst_ack", {7'd0, ack}, 8'd0);
    chk("rst_dout", {6'd0, data_out}, 8'd0);
    chk("rst_dbg0", dbg_data, 8'h00);
    rst = 1'b1;
    en  = 1'b1;

    // write A5 to reg 4
    dbg_addr = 3'd4;
    cyc(2'b01, 2'b00);
    chk("wr_busy", {7'd0, busy}, 8'd1);
    send(8'h67);
    send(8'hA5);
    chk("wr_ack", {7'd0, ack}, 8'd1);
    chk("wr_dbg", dbg_data, 8'hA5);
    cyc(2'b00, 2'b00);
    chk("wr_ack_1cyc", {7'd0, ack}, 8'd0);
    cyc(2'b11, 2'b00);
    chk("wr_idle", {7'd0, busy}, 8'd0);

    // read back reg 4
    cyc(2'b01, 2'b00);
    send(8'hA7);
    chk("rd_oe", {7'd0, data_oe}, 8'd1);
    chk("rd_first", {6'd0, data_out}, 8'h02);
    rec = 8'h00;
    for (int i = 0; i < 4; i++) begin
      rec = {rec[5:0], data_out};
      cyc(2'b10, 2'b00);
    end
    chk("rd_value", rec, 8'hA5);
    chk("rd_ack", {7'd0, ack}, 8'd1);
    chk("rd_oe_off", {7'd0, data_oe}, 8'd0);
    cyc(2'b11, 2'b00);

    // other slave id: ignored
    dbg_addr = 3'd2;
    cyc(2'b01, 2'b00);
    send(8'h53);
    send(8'h3C);
    chk("id_ack", {7'd0, ack}, 8'd0);
    chk("id_busy", {7'd0, busy}, 8'd1);
    chk("id_reg2", dbg_data, 8'h00);
    cyc(2'b11, 2'b00);
    chk("id_idle", {7'd0, busy}, 8'd0);

    // write 5A to reg 1 with waits between dibits
    dbg_addr = 3'd1;
    cyc(2'b01, 2'b00);
    send(8'h4F);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b00, 2'b00);
      cyc(2'b00, 2'b11);
      cyc(2'b10, 2'(8'h5A >> (6 - 2 * i)));
    end
    chk("wt_ack", {7'd0, ack}, 8'd1);
    chk("wt_dbg", dbg_data, 8'h5A);
    cyc(2'b11, 2'b00);

    // extra dibit after a completed write
    cyc(2'b01, 2'b00);
    send(8'h4F);
    send(8'hC3);
    cyc(2'b10, 2'b01);
    chk("xd_err", {7'd0, err}, 8'd1);
    chk("xd_dbg", dbg_data, 8'hC3);
    cyc(2'b11, 2'b00);

    // stop after two data dibits of reg 3 write
    dbg_addr = 3'd3;
    cyc(2'b01, 2'b00);
    send(8'h5F);
    cyc(2'b10, 2'b11);
    cyc(2'b10, 2'b00);
    cyc(2'b11, 2'b00);
    chk("ab_err", {7'd0, err}, 8'd1);
    chk("ab_ack", {7'd0, ack}, 8'd0);
    chk("ab_reg3", dbg_data, 8'h00);
    chk("ab_busy", {7'd0, busy}, 8'd0);

    // start mid-header, then a full frame
    cyc(2'b01, 2'b00);
    cyc(2'b10, 2'b01);
    cyc(2'b10, 2'b01);
    cyc(2'b01, 2'b00);
    chk("rs_err", {7'd0, err}, 8'd1);
    chk("rs_busy", {7'd0, busy}, 8'd1);
    send(8'h5F);
    send(8'h96);
    chk("rs_ack", {7'd0, ack}, 8'd1);
    chk("rs_reg3", dbg_data, 8'h96);
    cyc(2'b11, 2'b00);

    // async reset during read data phase
    cyc(2'b01, 2'b00);
    send(8'hA7);
    cyc(2'b10, 2'b00);
    cyc(2'b10, 2'b00);
    chk("ar_oe_pre", {7'd0, data_oe}, 8'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_oe", {7'd0, data_oe}, 8'd0);
    chk("ar_busy", {7'd0, busy}, 8'd0);
    chk("ar_ack", {7'd0, ack}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk("ar_reg", dbg_data, 8'h00);
    end
    ctrl = 2'b00;
    @(negedge clk);
    #1;
    rst = 1'b1;
    cyc(2'b00, 2'b00);
    cyc(2'b00, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fcp6_slave.md
Name: fcp6_slave

Overview:
Responder end of the FCP6 two-wire-dibit link. It sits opposite the FCP6 master in top-level integrations. It decodes header frames, services write and read transfers against an internal 8x8-bit register file, and returns ack and busy to the master. Only frames whose header slave-ID matches SLAVE_ID are serviced; all other frames are ignored silently.

Parameters:
SLAVE_ID, 3'b111, header[2:0] value this instance answers to
REG_INIT, 8'h00, reset value of every register-file entry

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous reset, ACTIVE-LOW (rst==0 resets)
ctrl  input  2  link control from master: 00 idle/wait, 01 start, 10 transfer, 11 stop
data_in  input  2  dibit from master, valid when ctrl==10
data_out  output  2  dibit to master during read data phase
data_oe  output  1  high while slave drives data_out
ack  output  1  one-cycle pulse: transfer completed
busy  output  1  high while slave is inside a matched or unmatched frame
err  output  1  one-cycle pulse: malformed/aborted frame
dbg_addr  input  3  debug register-file read address
dbg_data  output  8  combinational register-file contents at dbg_addr

Behaviour:
- Reset (rst==0, async): state=IDLE; data_out=00, data_oe=0, ack=0, busy=0, err=0; all registers=REG_INIT; shift/count cleared.
- Header byte: [7:6] op (01 write, 10 read, 00/11 reserved), [5:3] register address, [2:0] slave ID. Bytes move MSB-first, 4 dibits per byte, one dibit per ctrl==10 cycle.
- ctrl==00 inside a frame is a wait: state, counters and outputs hold (ack/err still one-cycle pulses).
- States:
  IDLE: ctrl==01 -> HDR, busy=1 next cycle, dibit count=0. Other ctrl values are ignored.
  HDR: shift in 4 dibits. On the 4th-dibit edge: if ID mismatch or op reserved -> SKIP. If write -> WDATA. If read -> RDATA, with data_out=reg[addr][7:6] and data_oe=1 registered on that same edge.
  WDATA: shift in 4 dibits. On the 4th edge, write the assembled byte to reg[addr] and go to DONE; ack=1 for exactly the following cycle.
  RDATA: each ctrl==10 edge advances data_out to the next dibit (7:6, 5:4, 3:2, 1:0). On the 4th edge, data_oe=0 and data_out=00, go to DONE; ack pulses one cycle. Read data is snapshotted into the shift register at header completion.
  DONE: ctrl==11 -> IDLE, busy=0 next cycle. ctrl==10 (extra dibit) -> err pulse, SKIP.
  SKIP: no writes, data_oe=0, no ack. ctrl==11 -> IDLE, busy low.
- ack is never asserted in SKIP or for unmatched IDs.
- Abort rules:
  ctrl==11 in HDR/WDATA/RDATA before the byte completes -> err pulse, IDLE, no register write, data_oe=0.
  ctrl==01 in any non-IDLE state -> err pulse, restart HDR with count=0 (busy stays 1).
- Latency: ack rises on the cycle after the final data dibit is sampled. A write is visible on dbg_data in that same cycle.
- A read of an address written in the immediately preceding frame returns the new value.
- Dibit counter is 2 bits and wraps; completion is decoded at count==3 with ctrl==10.
- Reset asserted mid-frame: immediate return to reset values; a partial write is discarded.

Test Plan:
- Write: ctrl 01, header 01_100_111 dibits 01,10,01,11, data A5 dibits 10,10,01,01, then ctrl 11 -> ack one cycle after last dibit; dbg_addr=4 gives A5; busy low after stop.
- Read back: header 10_100_111 then 4 ctrl==10 cycles -> data_out sequence 10,10,01,01 with data_oe=1, then ack; master reconstructs A5.
- ID mismatch: header 01_010_011 with data 3C -> no ack, no data_oe, reg[2] stays 00, busy high until stop.
- Waits: insert ctrl==00 cycles between every data dibit of a write of 5A to reg 1 -> result identical to the no-wait case; ack timing is relative to the last dibit.
- Abort: ctrl 11 after 2 data dibits of a write to reg 3 -> err pulse, reg 3 unchanged, no ack. ctrl 01 mid-header -> err pulse, then a following full frame completes correctly.
- Reset: drive rst=0 asynchronously in the middle of RDATA -> data_oe, busy and ack drop immediately; all registers read REG_INIT.
